if_stage: RTL

- Instruction fetch stage plus IF/ID pipeline register.
- Holds the PC and issues requests on a req/valid instruction-memory interface with variable latency.
- Captures each returned word into IF/ID, where the decode stage and imm_gen consume it.
- Handles pipeline stall from the hazard unit and redirect/flush from the branch unit.
- Discards responses that were in flight when a redirect occurred.

---
 rtl/if_stage_if.sv | 32 +++
 rtl/if_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : if_stage_if
//  Purpose  : Instruction-memory request/response bundle between the fetch
//             stage (master) and the instruction memory (slave).
//  Signals  : req   - fetch request, registered by the master
//             addr  - fetch address, held stable until valid is seen
//             valid - one-cycle response strobe for the current addr
//             rdata - instruction word, meaningful with valid
//  Revision : 1.0  initial release
// ============================================================================
interface if_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        valid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  valid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output valid,
    output rdata
  );
endinterface : if_stage_if
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : if_stage
//  Purpose  : Instruction fetch stage with IF/ID pipeline register. Holds the
//             PC, issues requests on a variable-latency req/valid memory,
//             captures returned words into IF/ID, handles stall (hold) and
//             redirect (flush + new PC), and drops responses that belong to a
//             request issued before a redirect.
//  Ports    : clk          - clock, rising edge
//             rst_n        - synchronous active-low reset
//             stall        - hold IF/ID and the PC
//             redirect     - taken branch/jump: flush IF/ID, fetch redirect_pc
//             redirect_pc  - new fetch address, used when redirect=1
//             imem         - instruction memory bundle (master side)
//             if_id_instr  - registered instruction to decode
//             if_id_pc     - registered PC of if_id_instr
//             if_id_valid  - if_id_instr is a real instruction
//             perf_fetched / perf_discarded - event counters, only present
//                            when IF_STAGE_PERF_CNT_EN is defined
//  Options  : IF_STAGE_PERF_CNT_EN - adds the two performance counters
//  Revision : 1.0  initial release
// ============================================================================
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        stall,
  input  wire logic        redirect,
  input  wire logic [31:0] redirect_pc,
  if_stage_if.master       imem,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_pc,
`ifdef IF_STAGE_PERF_CNT_EN
  output logic [31:0]      perf_fetched,
  output logic [31:0]      perf_discarded,
`endif
  output logic             if_id_valid
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_DISCARD = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic        ifid_valid_q, ifid_valid_d;

  // A strobe only counts while our request is actually up; anything the
  // memory drives with req low (e.g. right after reset) is ignored.
  logic        rsp_valid;
  logic [31:0] pc_inc;

  assign rsp_valid = imem.valid & req_q;
  assign pc_inc    = pc_q + 32'd4;   // natural 32-bit wrap

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    req_d        = req_q;
    buf_instr_d  = buf_instr_q;
    buf_pc_d     = buf_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;

    // IF/ID baseline: a redirect always flushes; otherwise stall holds and
    // no-stall inserts a bubble unless a real word is written below.
    if (redirect || !stall) begin
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end

    unique case (state_q)
      S_FETCH: begin
        if (redirect) begin
          pc_d = redirect_pc;
          // Only an outstanding, unanswered request needs its response
          // discarded; after reset req is still low and nothing is in flight.
          state_d = (req_q && !rsp_valid) ? S_DISCARD : S_FETCH;
        end else if (rsp_valid) begin
          pc_d = pc_inc;
          if (!stall) begin
            ifid_instr_d = imem.rdata;
            ifid_pc_d    = pc_q;
            ifid_valid_d = 1'b1;
          end else begin
            buf_instr_d = imem.rdata;
            buf_pc_d    = pc_q;
            state_d     = S_HOLD;
          end
        end
      end

      S_DISCARD: begin
        // pc already holds the redirect target; a further redirect simply
        // replaces it while we wait out the stale response.
        if (redirect) begin
          pc_d = redirect_pc;
        end
        if (rsp_valid) begin
          state_d = S_FETCH;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = S_FETCH;
        end else if (!stall) begin
          ifid_instr_d = buf_instr_q;
          ifid_pc_d    = buf_pc_q;
          ifid_valid_d = 1'b1;
          state_d      = S_FETCH;
        end
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Request outputs are registered from the next state. DISCARD keeps
    // the old address up so the stale response can complete cleanly.
    unique case (state_d)
      S_FETCH: begin
        req_d  = 1'b1;
        addr_d = pc_d;
      end
      S_DISCARD: begin
        req_d  = 1'b1;
        addr_d = addr_q;
      end
      default: begin
        req_d  = 1'b0;
        addr_d = addr_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      req_q        <= 1'b0;
      buf_instr_q  <= 32'd0;
      buf_pc_q     <= 32'd0;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= 32'd0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      req_q        <= req_d;
      buf_instr_q  <= buf_instr_d;
      buf_pc_q     <= buf_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign imem.req    = req_q;
  assign imem.addr   = addr_q;
  assign if_id_instr = ifid_instr_q;
  assign if_id_pc    = ifid_pc_q;
  assign if_id_valid = ifid_valid_q;

`ifdef IF_STAGE_PERF_CNT_EN
  logic        fetched_ev;
  logic        dropped_ev;
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_discarded_q;

  // A word lands in IF/ID either straight from memory or from the buffer.
  assign fetched_ev = ((state_q == S_FETCH) && rsp_valid && !redirect && !stall) ||
                      ((state_q == S_HOLD)  && !redirect && !stall);

  // Every returned word that never reaches IF/ID.
  assign dropped_ev = ((state_q == S_FETCH)   && rsp_valid && redirect) ||
                      ((state_q == S_DISCARD) && rsp_valid)             ||
                      ((state_q == S_HOLD)    && redirect);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched_q   <= 32'd0;
      perf_discarded_q <= 32'd0;
    end else begin
      if (fetched_ev) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      if (dropped_ev) begin
        perf_discarded_q <= perf_discarded_q + 32'd1;
      end
    end
  end

  assign perf_fetched   = perf_fetched_q;
  assign perf_discarded = perf_discarded_q;
`endif

endmodule : if_stage
`default_nettype wire
